// File: rtl/river_log_scroller.sv
// -----------------------------------------------------------------------------
// river_log_scroller
//
// Scrolls the logs of every river row horizontally, one pixel at a time, at a
// row-specific rate derived from the speed level. Positions wrap around the
// screen edge. Downstream collision and render logic consume the positions,
// the constant log widths and a per-row "moved this frame" pulse.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   frame_tick - one-cycle pulse per video frame
//   pause      - freezes all motion and counters while high
//   level      - speed level 0..7, higher is faster
//   log_x      - [row][log] left-edge x position, 0..SCREEN_WIDTH-1
//   log_width  - [row][log] log width, always LOG_WIDTH
//   row_step   - per-row pulse, high for one cycle after a 1-pixel move
//   row_dir    - per-row direction, 1 = right (+x), 0 = left (-x)
// -----------------------------------------------------------------------------
module river_log_scroller #(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_LOGS     = 2,
  parameter int SCREEN_WIDTH = 320,
  parameter int LOG_WIDTH    = 64,
  parameter int BASE_PERIOD  = 4,
  parameter int ROW_OFFSET   = 40
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    frame_tick,
  input  logic                                    pause,
  input  logic [2:0]                              level,
  output logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0]  log_x,
  output logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0]  log_width,
  output logic [NUM_ROWS-1:0]                     row_step,
  output logic [NUM_ROWS-1:0]                     row_dir
);

  // Wide enough for any period BASE_PERIOD + r with the default geometry and
  // comfortably beyond the 5-bit minimum.
  localparam int CNT_W = 8;
  localparam logic [9:0] X_MAX = 10'(SCREEN_WIDTH - 1);

  // Frames per step for row r: BASE_PERIOD + r - level, clamped to at least 1.
  function automatic logic [CNT_W-1:0] row_period(input int r, input logic [2:0] lvl);
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] lvl_w;
    base  = CNT_W'(BASE_PERIOD + r);
    lvl_w = CNT_W'(lvl);
    if (base > lvl_w) begin
      return base - lvl_w;
    end
    return CNT_W'(1);
  endfunction

  // Staggered starting position: logs evenly spaced in a row, rows offset.
  function automatic logic [9:0] init_x(input int r, input int i);
    return 10'(((i * SCREEN_WIDTH) / NUM_LOGS + r * ROW_OFFSET) % SCREEN_WIDTH);
  endfunction

  // Even rows travel right, odd rows travel left.
  function automatic logic dir_of(input int r);
    return ((r % 2) == 0);
  endfunction

  // One-pixel move with wrap; never produces a value >= SCREEN_WIDTH.
  function automatic logic [9:0] wrap_step(input logic [9:0] x, input logic dir);
    if (dir) begin
      return (x == X_MAX) ? 10'd0 : x + 10'd1;
    end
    return (x == 10'd0) ? X_MAX : x - 10'd1;
  endfunction

  logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0] x_q, x_d;
  logic [CNT_W-1:0]                       cnt_q [NUM_ROWS];
  logic [CNT_W-1:0]                       cnt_d [NUM_ROWS];
  logic [NUM_ROWS-1:0]                    step_q, step_d;
  logic                                   accept;

  assign accept = frame_tick & ~pause;

  // Next-state: on an accepted tick each row either advances its frame
  // counter or, when the period is reached, clears it and moves all its logs.
  // The period is sampled from the current level at the tick itself, so a
  // level change only takes effect on the next accepted tick.
  always_comb begin
    x_d    = x_q;
    step_d = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (accept) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (({1'b0, cnt_q[r]} + 9'd1) >= {1'b0, row_period(r, level)}) begin
          cnt_d[r]  = '0;
          step_d[r] = 1'b1;
          for (int i = 0; i < NUM_LOGS; i++) begin
            x_d[r][i] = wrap_step(x_q[r][i], dir_of(r));
          end
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end
    end
  end

  // Single registered stage: positions and step pulses appear the cycle
  // after the accepted tick. step_d defaults to 0, so the pulse lasts exactly
  // one cycle per tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        cnt_q[r] <= '0;
        for (int i = 0; i < NUM_LOGS; i++) begin
          x_q[r][i] <= init_x(r, i);
        end
      end
    end else begin
      step_q <= step_d;
      x_q    <= x_d;
      for (int r = 0; r < NUM_ROWS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Constant outputs, independent of reset.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_dir[r] = dir_of(r);
      for (int i = 0; i < NUM_LOGS; i++) begin
        log_width[r][i] = 10'(LOG_WIDTH);
      end
    end
  end

  assign log_x    = x_q;
  assign row_step = step_q;

endmodule

// File: tb/tb_river_log_scroller.sv
module tb_river_log_scroller;

  localparam int NR  = 4;
  localparam int NL  = 2;
  localparam int SW  = 320;
  localparam int LW  = 64;
  localparam int BP  = 4;
  localparam int RO  = 40;

  logic                        clk;
  logic                        reset;
  logic                        frame_tick;
  logic                        pause;
  logic [2:0]                  level;
  logic [0:NR-1][0:NL-1][9:0]  log_x;
  logic [0:NR-1][0:NL-1][9:0]  log_width;
  logic [NR-1:0]               row_step;
  logic [NR-1:0]               row_dir;

  int errors = 0;
  int checks = 0;

  // Reference model: per-row frame count and total number of steps taken.
  // A log's position is its starting position displaced by the step count in
  // the row's direction, reduced modulo the screen width.
  int          mcnt [NR];
  int          msteps [NR];
  logic [NR-1:0] exp_step;

  river_log_scroller #(
    .NUM_ROWS(NR), .NUM_LOGS(NL), .SCREEN_WIDTH(SW),
    .LOG_WIDTH(LW), .BASE_PERIOD(BP), .ROW_OFFSET(RO)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .level(level), .log_x(log_x), .log_width(log_width),
    .row_step(row_step), .row_dir(row_dir)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int start_x(input int r, input int i);
    return (i * SW / NL + r * RO) % SW;
  endfunction

  function automatic int exp_x(input int r, input int i);
    int v;
    v = start_x(r, i) + (((r % 2) == 0) ? msteps[r] : -msteps[r]);
    return ((v % SW) + SW) % SW;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mcnt[r]   = 0;
      msteps[r] = 0;
    end
    exp_step = '0;
  endtask

  task automatic model_tick(input int lvl);
    int p;
    exp_step = '0;
    for (int r = 0; r < NR; r++) begin
      p = BP + r - lvl;
      if (p < 1) p = 1;
      if (mcnt[r] + 1 >= p) begin
        mcnt[r]     = 0;
        msteps[r]  += 1;
        exp_step[r] = 1'b1;
      end else begin
        mcnt[r] += 1;
      end
    end
  endtask

  // Drive one clock cycle of stimulus, then update the model; outputs are
  // sampled 1 time unit after the edge by the caller.
  task automatic cycle(input bit t, input bit p, input logic [2:0] l);
    @(negedge clk);
    frame_tick = t;
    pause      = p;
    level      = l;
    @(posedge clk);
    #1;
    frame_tick = 0;
    if (t && !p) model_tick(int'(l));
    else exp_step = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1; frame_tick = 0; pause = 0; level = 0;
    repeat (3) @(negedge clk);
    model_reset();
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (log_x[r][i] !== 10'(start_x(r, i))) begin
          errors++;
          $display("FAIL reset_x[%0d][%0d] got %0d expected %0d", r, i, log_x[r][i], start_x(r, i));
        end
        checks++;
        if (log_width[r][i] !== 10'(LW)) begin
          errors++;
          $display("FAIL reset_width[%0d][%0d] got %0d expected %0d", r, i, log_width[r][i], LW);
        end
      end
    end
    checks++;
    if (row_step !== 4'b0000) begin
      errors++;
      $display("FAIL reset_row_step got %b expected 0000", row_step);
    end
    checks++;
    if (row_dir !== 4'b0101) begin
      errors++;
      $display("FAIL reset_row_dir got %b expected 0101", row_dir);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_level0();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 0, 3'd0);
      checks++;
      if (row_step[0] !== (k == 4)) begin
        errors++;
        $display("FAIL lvl0_step0 tick %0d got %b expected %b", k, row_step[0], (k == 4));
      end
      checks++;
      if (row_step !== exp_step) begin
        errors++;
        $display("FAIL lvl0_row_step tick %0d got %b expected %b", k, row_step, exp_step);
      end
      if (k == 4) begin
        checks++;
        if (log_x[0][0] !== 10'd1) begin
          errors++;
          $display("FAIL lvl0_row0_x got %0d expected 1", log_x[0][0]);
        end
        cycle(0, 0, 3'd0);
        checks++;
        if (row_step !== 4'b0000) begin
          errors++;
          $display("FAIL lvl0_pulse_width got %b expected 0000", row_step);
        end
      end
    end
    checks++;
    if (log_x[1][0] !== 10'd39) begin
      errors++;
      $display("FAIL lvl0_row1_x got %0d expected 39", log_x[1][0]);
    end
    for (int r = 2; r < NR; r++) begin
      checks++;
      if (log_x[r][0] !== 10'(start_x(r, 0))) begin
        errors++;
        $display("FAIL lvl0_row%0d_unchanged got %0d expected %0d", r, log_x[r][0], start_x(r, 0));
      end
    end
  endtask

  task automatic test_level7_wrap();
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      cycle(1, 0, 3'd7);
      checks++;
      if (row_step !== 4'b1111) begin
        errors++;
        $display("FAIL lvl7_row_step tick %0d got %b expected 1111", k, row_step);
      end
      if (k == 41) begin
        checks++;
        if (log_x[1][0] !== 10'd319) begin
          errors++;
          $display("FAIL lvl7_left_wrap got %0d expected 319", log_x[1][0]);
        end
        checks++;
        if (log_x[0][1] !== 10'd201) begin
          errors++;
          $display("FAIL lvl7_row0_log1 got %0d expected 201", log_x[0][1]);
        end
        checks++;
        if (log_x[3][0] !== 10'd79) begin
          errors++;
          $display("FAIL lvl7_row3_log0 got %0d expected 79", log_x[3][0]);
        end
      end
    end
    checks++;
    if (log_x[2][1] !== 10'd0) begin
      errors++;
      $display("FAIL lvl7_right_wrap got %0d expected 0", log_x[2][1]);
    end
    checks++;
    if (log_x[2][0] !== 10'd160) begin
      errors++;
      $display("FAIL lvl7_row2_log0 got %0d expected 160", log_x[2][0]);
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1, 1, 3'd7);
      checks++;
      if (row_step !== 4'b0000) begin
        errors++;
        $display("FAIL pause_row_step got %b expected 0000", row_step);
      end
      for (int r = 0; r < NR; r++) begin
        checks++;
        if (log_x[r][1] !== 10'(start_x(r, 1))) begin
          errors++;
          $display("FAIL pause_hold_x[%0d] got %0d expected %0d", r, log_x[r][1], start_x(r, 1));
        end
      end
    end
    cycle(1, 0, 3'd7);
    checks++;
    if (row_step !== 4'b1111) begin
      errors++;
      $display("FAIL unpause_row_step got %b expected 1111", row_step);
    end
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (log_x[r][i] !== 10'(exp_x(r, i))) begin
          errors++;
          $display("FAIL unpause_x[%0d][%0d] got %0d expected %0d", r, i, log_x[r][i], exp_x(r, i));
        end
      end
    end
    cycle(0, 0, 3'd7);
    checks++;
    if (row_step !== 4'b0000) begin
      errors++;
      $display("FAIL unpause_pulse_width got %b expected 0000", row_step);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (20) cycle(1, 0, 3'd7);
    // Assert reset mid-cycle, well clear of the next rising edge.
    #2;
    reset = 1;
    #1;
    model_reset();
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (log_x[r][i] !== 10'(start_x(r, i))) begin
          errors++;
          $display("FAIL async_reset_x[%0d][%0d] got %0d expected %0d", r, i, log_x[r][i], start_x(r, i));
        end
      end
    end
    checks++;
    if (row_step !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_row_step got %b expected 0000", row_step);
    end
    @(negedge clk);
    reset = 0;
    // Counters must restart from zero: row 0 moves only on the 4th tick.
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 3'd0);
      checks++;
      if (log_x[0][0] !== 10'(exp_x(0, 0)) || row_step !== exp_step) begin
        errors++;
        $display("FAIL async_restart tick %0d got x=%0d step=%b expected x=%0d step=%b",
                 k, log_x[0][0], row_step, exp_x(0, 0), exp_step);
      end
    end
  endtask

  task automatic test_random();
    bit         t, p;
    logic [2:0] l;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      t = ($urandom_range(0, 1) == 1);
      p = ($urandom_range(0, 3) == 0);
      l = 3'($urandom_range(0, 7));
      cycle(t, p, l);
      checks++;
      if (row_step !== exp_step) begin
        errors++;
        $display("FAIL rand_row_step cyc %0d got %b expected %b", k, row_step, exp_step);
      end
      for (int r = 0; r < NR; r++) begin
        for (int i = 0; i < NL; i++) begin
          checks++;
          if (log_x[r][i] !== 10'(exp_x(r, i))) begin
            errors++;
            $display("FAIL rand_x[%0d][%0d] cyc %0d got %0d expected %0d", r, i, k, log_x[r][i], exp_x(r, i));
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1; frame_tick = 0; pause = 0; level = 0;
    model_reset();
    test_reset();
    test_level0();
    test_level7_wrap();
    test_pause();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/river_log_scroller.md
Name: river_log_scroller

Overview:
- Produces the river log positions that the frog-on-river logic consumes: per-row, per-log x positions, log widths, and a per-row "moved this frame" step/direction.
- Each river row scrolls its logs horizontally at a row-specific rate, with wrap-around at the screen edge.
- Sits between the frame-timing logic (frame_tick) and the frog/river collision and renderer blocks.

Parameters:
- NUM_ROWS, 4, number of river rows.
- NUM_LOGS, 2, logs per row.
- SCREEN_WIDTH, 320, horizontal wrap modulus in pixels; legal x range is 0..SCREEN_WIDTH-1.
- LOG_WIDTH, 64, width in pixels reported for every log.
- BASE_PERIOD, 4, frames per 1-pixel step for row 0 at level 0.
- ROW_OFFSET, 40, initial x stagger between adjacent rows.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- pause, input, 1, freezes all motion and counters while high.
- level, input, 3, speed level 0..7; higher is faster.
- log_x, output, [0:NUM_ROWS-1][0:NUM_LOGS-1] x 10, log left-edge x position.
- log_width, output, [0:NUM_ROWS-1][0:NUM_LOGS-1] x 10, log width; constant LOG_WIDTH.
- row_step, output, NUM_ROWS, one-cycle pulse: the row moved 1 pixel this frame.
- row_dir, output, NUM_ROWS, row direction: 1 = right (+x), 0 = left (-x).

Behaviour:
- Reset (async, reset high):
  - log_x[r][i] = (i*SCREEN_WIDTH/NUM_LOGS + r*ROW_OFFSET) mod SCREEN_WIDTH.
  - Per-row counters cleared to 0; row_step = 0.
- row_dir[r] is constant: even r = 1 (right), odd r = 0 (left). log_width is always LOG_WIDTH. Both are held during reset.
- Row period: period_r = max(1, BASE_PERIOD + r - level). Computed in unsigned arithmetic at least 5 bits wide; a negative or zero result clamps to 1.
- A tick is accepted when frame_tick = 1 and pause = 0. Per row, on an accepted tick at cycle N:
  - If cnt_r + 1 >= period_r: cnt_r <= 0, every log in the row moves 1 pixel in row_dir[r], and row_step[r] = 1 during cycle N+1 only.
  - Else: cnt_r <= cnt_r + 1, no move.
- Latency: updated log_x and row_step are visible in cycle N+1 (one registered stage). row_step is never high for two consecutive cycles from a single tick.
- Wrap-around:
  - Right move with x = SCREEN_WIDTH-1 gives 0.
  - Left move with x = 0 gives SCREEN_WIDTH-1.
  - No intermediate value is ever >= SCREEN_WIDTH.
- pause = 1 together with frame_tick: the tick is ignored; counters and positions hold; row_step = 0.
- level changing mid-count: the new period takes effect at the next accepted tick. If cnt_r + 1 >= new period, the row steps on that tick and the counter clears. There is no spurious step without a tick.
- frame_tick held high for several cycles: each high cycle counts as a tick. Upstream guarantees single-cycle pulses; this block adds no edge detection.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. Operation resumes on the first accepted tick after reset deasserts.
- Logs within a row move together; their relative spacing is invariant modulo SCREEN_WIDTH.

Test Plan:
- Reset with default parameters -> log_x row0 = {0,160}, row1 = {40,200}, row2 = {80,240}, row3 = {120,280}; row_step = 0; row_dir = 4'b0101 (bit r = row r).
- level = 0, 4 accepted ticks -> row0 log0 = 1 and row_step[0] pulses once, on the cycle after tick 4. Add 1 more tick (5 total) -> row1 log0 = 39; rows 2 and 3 unchanged.
- level = 7 (all periods clamp to 1), 41 ticks -> row1 log0 = 319 (left wrap); row0 log1 = 201; row3 log0 = 79. row_step = 4'b1111 after every tick.
- level = 7, 80 ticks -> row2 log1 = 0 (right wrap at 319 -> 0); row2 log0 = 160.
- pause = 1 with 10 ticks, then pause = 0 with 1 tick at level 7 -> positions unchanged through the paused ticks, then all rows step exactly once. row_step stays 0 while paused.
- Async reset asserted between clock edges after 20 level-7 ticks -> outputs return to the reset values before the next clk edge; counters restart from 0.
